ascii_hex_reader: RTL and testbench

ASCII_HEX_READER -- requirements
Module: ascii_hex_reader

---
 rtl/osd_pkg.sv | 17 +
 rtl/ascii_hex_nibble_decode.sv | 26 ++
 rtl/ascii_hex_reader.sv | 96 +++++++++
 tb/tb_ascii_hex_reader.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared OSD text-buffer constants, ASCII hex digit bounds and reader state type.
package osd_pkg;
  localparam int OSD_ADDR_W = 7;
  localparam int OSD_COLS   = 16;
  localparam int OSD_ROWS   = 8;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UF = 8'h46;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h66;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ_HI, ST_CAP_HI, ST_REQ_LO, ST_CAP_LO, ST_DONE
  } osd_state_t;
endpackage

// File: rtl/ascii_hex_nibble_decode.sv
// One ASCII hex digit to a nibble. Define OSD_HEX_READER_LOWERCASE_EN to also accept 'a'-'f'.
module ascii_hex_nibble_decode
  import osd_pkg::*;
(
  input  logic [7:0] ch,
  output logic [3:0] nib,
  output logic       valid
);
  always_comb begin
    nib   = '0;
    valid = 1'b0;
    if (ch >= ASCII_0 && ch <= ASCII_9) begin
      nib   = 4'(ch - ASCII_0);
      valid = 1'b1;
    end else if (ch >= ASCII_UA && ch <= ASCII_UF) begin
      nib   = 4'(ch - ASCII_UA + 8'd10);
      valid = 1'b1;
    end
`ifdef OSD_HEX_READER_LOWERCASE_EN
    else if (ch >= ASCII_LA && ch <= ASCII_LF) begin
      nib   = 4'(ch - ASCII_LA + 8'd10);
      valid = 1'b1;
    end
`endif
  end
endmodule

// File: rtl/ascii_hex_reader.sv
// Reads two adjacent OSD characters through a shared, arbitrated read port and decodes them as a hex byte.
// Lowercase digits are accepted when OSD_HEX_READER_LOWERCASE_EN is defined (see ascii_hex_nibble_decode).
module ascii_hex_reader
  import osd_pkg::*;
#(
  parameter int COLS = OSD_COLS,
  parameter int ROWS = OSD_ROWS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [3:0]            linea,
  input  logic [4:0]            columna,
  output logic                  rd_req,
  input  logic                  rd_gnt,
  output logic [OSD_ADDR_W-1:0] rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            value,
  output logic                  err
);
  osd_state_t state, nxt;
  logic [OSD_ADDR_W-1:0] base, base_in;
  logic [7:0] hi_ch;
  logic       oob;
  logic [3:0] hi_nib, lo_nib;
  logic       hi_ok, lo_ok;

  // Both digits must fit on the line, so the high digit may not sit in the last column.
  assign oob     = (int'(linea) >= ROWS) || (int'(columna) + 1 >= COLS);
  assign base_in = OSD_ADDR_W'(int'(linea) * COLS + int'(columna));

  ascii_hex_nibble_decode u_dec_hi (.ch(hi_ch),   .nib(hi_nib), .valid(hi_ok));
  ascii_hex_nibble_decode u_dec_lo (.ch(rd_data), .nib(lo_nib), .valid(lo_ok));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (start) nxt = oob ? ST_DONE : ST_REQ_HI;
      ST_REQ_HI: if (rd_gnt) nxt = ST_CAP_HI;
      ST_CAP_HI: nxt = ST_REQ_LO;
      ST_REQ_LO: if (rd_gnt) nxt = ST_CAP_LO;
      ST_CAP_LO: nxt = ST_DONE;
      ST_DONE:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Result is written on the edge into DONE so value/err are valid alongside the done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base  <= '0;
      hi_ch <= '0;
      value <= '0;
      err   <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        base <= base_in;
        if (oob) begin
          value <= '0;
          err   <= 1'b1;
        end
      end
      if (state == ST_CAP_HI) hi_ch <= rd_data;
      if (state == ST_CAP_LO) begin
        if (hi_ok && lo_ok) begin
          value <= {hi_nib, lo_nib};
          err   <= 1'b0;
        end else begin
          value <= '0;
          err   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_req  = 1'b0;
    rd_addr = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_REQ_HI: begin rd_req = 1'b1; rd_addr = base;                     busy = 1'b1; end
      ST_REQ_LO: begin rd_req = 1'b1; rd_addr = base + OSD_ADDR_W'(1);   busy = 1'b1; end
      ST_CAP_HI, ST_CAP_LO: busy = 1'b1;
      ST_DONE:   done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ascii_hex_reader.sv
// Directed bench for ascii_hex_reader with a behavioural text buffer and configurable grant delay.
module tb_ascii_hex_reader;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] linea;
  logic [4:0] columna;
  logic       rd_req, rd_gnt, busy, done, err;
  logic [6:0] rd_addr;
  logic [7:0] rd_data, value;

  logic [7:0] mem [128];
  int  checks = 0;
  int  errors = 0;
  int  gnt_delay = 0;
  bit  force_gnt = 1'b1;
  int  wcnt = 0;

  always #5 clk = ~clk;

  ascii_hex_reader #(.COLS(16), .ROWS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .linea(linea), .columna(columna),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .value(value), .err(err)
  );

  // Buffer returns data one cycle after a granted request, junk otherwise.
  assign rd_gnt = force_gnt | (rd_req & (wcnt >= gnt_delay));
  always @(posedge clk) begin
    rd_data <= (rd_req && rd_gnt) ? mem[rd_addr] : 8'hEE;
    wcnt    <= (rd_req && !rd_gnt) ? wcnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".rd_req"}, 32'(rd_req), 0);
    chk({tag, ".rd_addr"}, 32'(rd_addr), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".value"}, 32'(value), 0);
    chk({tag, ".err"}, 32'(err), 0);
  endtask

  task automatic run_txn(input string tag, input logic [3:0] l, input logic [4:0] c,
                         input int gd, input bit fg, input logic [6:0] ea,
                         input logic [7:0] ev, input logic ee, input int elat,
                         input int enreq, input int dup_at);
    int cyc, ngr, bad;
    logic [6:0] a0, a1, expa;
    bit got, busy1;
    gnt_delay = gd; force_gnt = fg;
    ngr = 0; bad = 0; got = 0; a0 = '0; a1 = '0;
    @(negedge clk);
    start = 1'b1; linea = l; columna = c;
    @(negedge clk);
    cyc = 1; busy1 = busy;
    while (cyc < 60 && !got) begin
      if (cyc == dup_at) begin start = 1'b1; linea = 4'd0; columna = 5'd0; end
      else start = 1'b0;
      if (done) got = 1'b1;
      else begin
        if (rd_req) begin
          expa = (ngr == 0) ? ea : ea + 7'd1;
          if (rd_addr !== expa) bad++;
          if (rd_gnt) begin
            if (ngr == 0) a0 = rd_addr; else a1 = rd_addr;
            ngr++;
          end
        end else if (rd_addr !== 7'd0) bad++;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(cyc), 32'(elat));
    chk({tag, ".value"}, 32'(value), 32'(ev));
    chk({tag, ".err"}, 32'(err), 32'(ee));
    chk({tag, ".busy_at_done"}, 32'(busy), 0);
    if (elat > 1) chk({tag, ".busy_during"}, 32'(busy1), 1);
    chk({tag, ".grants"}, 32'(ngr), 32'(enreq));
    chk({tag, ".addr_stable"}, 32'(bad), 0);
    if (enreq == 2) begin
      chk({tag, ".addr_hi"}, 32'(a0), 32'(ea));
      chk({tag, ".addr_lo"}, 32'(a1), 32'(ea + 7'd1));
    end
    @(negedge clk);
    chk({tag, ".single_done"}, 32'(done), 0);
    chk({tag, ".idle_after"}, 32'(busy | rd_req), 0);
    chk({tag, ".value_held"}, 32'(value), 32'(ev));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h3F;
    mem[24] = "3";  mem[25] = "C";
    mem[32] = "G";  mem[33] = "1";
    mem[52] = "a";  mem[53] = "5";
    mem[14] = "9";  mem[15] = "A";
    mem[112] = "0"; mem[113] = "F";
    mem[64] = ":";  mem[65] = "0";
    mem[80] = "F";  mem[81] = "@";

    reset_n = 1'b0; start = 1'b0; linea = '0; columna = '0;
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_txn("hex3C",      4'd1, 5'd8,  0, 1'b1, 7'd24,  8'h3C, 1'b0, 5, 2, 0);
    run_txn("hex3C_wait", 4'd1, 5'd8,  3, 1'b0, 7'd24,  8'h3C, 1'b0, 11, 2, 0);
    run_txn("badG1",      4'd2, 5'd0,  0, 1'b1, 7'd32,  8'h00, 1'b1, 5, 2, 0);
`ifdef OSD_HEX_READER_LOWERCASE_EN
    run_txn("lower_a5",   4'd3, 5'd4,  0, 1'b1, 7'd52,  8'hA5, 1'b0, 5, 2, 0);
`else
    run_txn("lower_a5",   4'd3, 5'd4,  0, 1'b1, 7'd52,  8'h00, 1'b1, 5, 2, 0);
`endif
    run_txn("hex9A_c14",  4'd0, 5'd14, 0, 1'b1, 7'd14,  8'h9A, 1'b0, 5, 2, 0);
    run_txn("hex0F_r7",   4'd7, 5'd0,  1, 1'b0, 7'd112, 8'h0F, 1'b0, 7, 2, 0);
    run_txn("colon",      4'd4, 5'd0,  0, 1'b1, 7'd64,  8'h00, 1'b1, 5, 2, 0);
    run_txn("at_lo",      4'd5, 5'd0,  0, 1'b1, 7'd80,  8'h00, 1'b1, 5, 2, 0);
    run_txn("oob_col15",  4'd0, 5'd15, 0, 1'b1, 7'd0,   8'h00, 1'b1, 1, 0, 0);
    run_txn("oob_line8",  4'd8, 5'd0,  0, 1'b1, 7'd0,   8'h00, 1'b1, 1, 0, 0);
    run_txn("dup_start",  4'd1, 5'd8,  0, 1'b1, 7'd24,  8'h3C, 1'b0, 5, 2, 2);

    // Abort in CAP_HI: start in cycle 0, REQ_HI in cycle 1, CAP_HI in cycle 2.
    gnt_delay = 0; force_gnt = 1'b1;
    @(negedge clk);
    start = 1'b1; linea = 4'd2; columna = 5'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    begin
      int seen_done = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (done || busy || rd_req) seen_done++;
      end
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (done || busy || rd_req) seen_done++;
      end
      chk("mid_reset.no_done", 32'(seen_done), 0);
    end
    run_txn("after_reset", 4'd1, 5'd8, 0, 1'b1, 7'd24, 8'h3C, 1'b0, 5, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
